// File: rtl/ppu_render_timing.sv
// Dot/scanline timing generator: raster counters, odd-frame dot skip and the per-dot
// strobes that drive loopy-address updates, vblank status and background fetches.
module ppu_render_timing #(
  parameter int unsigned DOTS_PER_LINE   = 341,
  parameter int unsigned LINES_PER_FRAME = 262,
  parameter int unsigned VISIBLE_LINES   = 240,
  parameter int unsigned VBLANK_LINE     = 241,
  parameter int unsigned PRERENDER_LINE  = 261
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clkEn,
  input  logic       background_EN,
  input  logic       sprite_EN,
  output logic [8:0] dot,
  output logic [8:0] scanline,
  output logic       oddFrame,
  output logic       renderingEnabled,
  output logic       visiblePixel,
  output logic       setVerticalBlank,
  output logic       clearVerticalBlank,
  output logic       incrementX,
  output logic       incrementY,
  output logic       resetX,
  output logic       resetY,
  output logic       oamReset,
  output logic       fetchStrobe,
  output logic [1:0] fetchStage
);

  localparam logic [8:0] LastDot    = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] SkipDot    = 9'(DOTS_PER_LINE - 2);
  localparam logic [8:0] LastLine   = 9'(LINES_PER_FRAME - 1);
  localparam logic [8:0] VisLines   = 9'(VISIBLE_LINES);
  localparam logic [8:0] VblankLine = 9'(VBLANK_LINE);
  localparam logic [8:0] PreLine    = 9'(PRERENDER_LINE);

  logic oddSkip;
  logic renderLine;
  logic strobeEn;
  logic renderStrobe;
  logic coarseXDot;
  logic fetchSlot;

  assign renderingEnabled = background_EN | sprite_EN;

  // Rendering is sampled only here, on the last dot before the skipped one.
  assign oddSkip = (scanline == PreLine) && (dot == SkipDot) && oddFrame && renderingEnabled;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dot      <= '0;
      scanline <= '0;
      oddFrame <= 1'b0;
    end else if (clkEn) begin
      if (oddSkip) begin
        dot      <= '0;
        scanline <= '0;
        oddFrame <= ~oddFrame;
      end else if (dot == LastDot) begin
        dot <= '0;
        if (scanline == LastLine) begin
          scanline <= '0;
          oddFrame <= ~oddFrame;
        end else begin
          scanline <= scanline + 9'd1;
        end
      end else begin
        dot <= dot + 9'd1;
      end
    end
  end

  assign visiblePixel = (scanline < VisLines) && (dot >= 9'd1) && (dot <= 9'd256);

  assign renderLine   = (scanline < VisLines) || (scanline == PreLine);
  assign strobeEn     = clkEn & ~reset;
  assign renderStrobe = strobeEn & renderingEnabled & renderLine;

  assign coarseXDot = ((dot >= 9'd8) && (dot <= 9'd256) && (dot[2:0] == 3'd0)) ||
                      (dot == 9'd328) || (dot == 9'd336);
  assign fetchSlot  = dot[0] && ((dot <= 9'd256) || ((dot >= 9'd321) && (dot <= 9'd336)));

  assign setVerticalBlank   = strobeEn && (scanline == VblankLine) && (dot == 9'd1);
  assign clearVerticalBlank = strobeEn && (scanline == PreLine) && (dot == 9'd1);

  assign incrementX = renderStrobe && coarseXDot;
  assign incrementY = renderStrobe && (dot == 9'd256);
  assign resetX     = renderStrobe && (dot == 9'd257);
  assign resetY     = renderStrobe && (scanline == PreLine) && (dot >= 9'd280) && (dot <= 9'd304);
  assign oamReset   = renderStrobe && (dot >= 9'd257) && (dot <= 9'd320);

  // On odd dots, bits [2:1] equal ((dot-1)>>1)&3: NT, AT, PT lo, PT hi.
  assign fetchStrobe = renderStrobe && fetchSlot;
  assign fetchStage  = fetchStrobe ? dot[2:1] : 2'd0;

endmodule

// File: tb/tb_ppu_render_timing.sv
// Scoreboard bench: a full-size instance and a short-frame instance share randomized
// stimulus and are checked against a behavioural raster model plus directed measurements.
module tb_ppu_render_timing;

  typedef struct packed {
    logic [8:0] dot;
    logic [8:0] line;
    logic       odd;
    logic       ren;
    logic       vis;
    logic       setVb;
    logic       clrVb;
    logic       incX;
    logic       incY;
    logic       rstX;
    logic       rstY;
    logic       oamR;
    logic       fStr;
    logic [1:0] fStg;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clkEn = 1'b0;
  logic backgroundEn = 1'b0;
  logic spriteEn = 1'b0;

  logic [8:0] bDot, bLine, sDot, sLine;
  logic       bOdd, bRen, bVis, bSetVb, bClrVb, bIncX, bIncY, bRstX, bRstY, bOam, bFs;
  logic       sOdd, sRen, sVis, sSetVb, sClrVb, sIncX, sIncY, sRstX, sRstY, sOam, sFs;
  logic [1:0] bFstg, sFstg;
  exp_t       bAct, sAct;

  always #5 clk = ~clk;

  ppu_render_timing dutBig (
    .clk(clk), .reset(reset), .clkEn(clkEn),
    .background_EN(backgroundEn), .sprite_EN(spriteEn),
    .dot(bDot), .scanline(bLine), .oddFrame(bOdd), .renderingEnabled(bRen),
    .visiblePixel(bVis), .setVerticalBlank(bSetVb), .clearVerticalBlank(bClrVb),
    .incrementX(bIncX), .incrementY(bIncY), .resetX(bRstX), .resetY(bRstY),
    .oamReset(bOam), .fetchStrobe(bFs), .fetchStage(bFstg)
  );

  // Short frame so that several frames, including odd-frame skips, fit in the run.
  ppu_render_timing #(
    .DOTS_PER_LINE(341), .LINES_PER_FRAME(8), .VISIBLE_LINES(4),
    .VBLANK_LINE(5), .PRERENDER_LINE(7)
  ) dutSmall (
    .clk(clk), .reset(reset), .clkEn(clkEn),
    .background_EN(backgroundEn), .sprite_EN(spriteEn),
    .dot(sDot), .scanline(sLine), .oddFrame(sOdd), .renderingEnabled(sRen),
    .visiblePixel(sVis), .setVerticalBlank(sSetVb), .clearVerticalBlank(sClrVb),
    .incrementX(sIncX), .incrementY(sIncY), .resetX(sRstX), .resetY(sRstY),
    .oamReset(sOam), .fetchStrobe(sFs), .fetchStage(sFstg)
  );

  assign bAct = {bDot, bLine, bOdd, bRen, bVis, bSetVb, bClrVb, bIncX, bIncY, bRstX, bRstY,
                 bOam, bFs, bFstg};
  assign sAct = {sDot, sLine, sOdd, sRen, sVis, sSetVb, sClrVb, sIncX, sIncY, sRstX, sRstY,
                 sOam, sFs, sFstg};

  int compareCount = 0;
  int mismatchCount = 0;
  int printed = 0;

  exp_t qExp[2][$];
  int md[2], ml[2];
  bit mo[2];
  int linesCfg[2] = '{262, 8};
  int visCfg[2]   = '{240, 4};
  int vbCfg[2]    = '{241, 5};
  int preCfg[2]   = '{261, 7};

  // Directed measurement state, driven by the monitor.
  bit measure = 1'b0;
  int cycIdx = 0;
  int starts[$];
  int vbFirst = -1;
  int l10IncX = 0, l10IncY = 0, l10Both = 0, l10RstX = 0, l10Oam = 0, l10RstY = 0;
  int preRstY = 0;
  int rstStrobes = 0;

  function automatic exp_t mk(int d, int l, bit odd, bit ren, bit en, int visL, int vbL,
                              int preL);
    exp_t e;
    bit rs;
    e = '0;
    e.dot   = 9'(d);
    e.line  = 9'(l);
    e.odd   = odd;
    e.ren   = ren;
    e.vis   = (l < visL) && (d >= 1) && (d <= 256);
    e.setVb = en && (l == vbL) && (d == 1);
    e.clrVb = en && (l == preL) && (d == 1);
    rs      = en && ren && ((l < visL) || (l == preL));
    e.incX  = rs && (((d >= 8) && (d <= 256) && (d % 8 == 0)) || (d == 328) || (d == 336));
    e.incY  = rs && (d == 256);
    e.rstX  = rs && (d == 257);
    e.rstY  = rs && (l == preL) && (d >= 280) && (d <= 304);
    e.oamR  = rs && (d >= 257) && (d <= 320);
    e.fStr  = rs && (d % 2 == 1) && ((d <= 256) || ((d >= 321) && (d <= 336)));
    e.fStg  = e.fStr ? 2'(((d - 1) / 2) % 4) : 2'd0;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    compareCount++;
    if (act != exp) begin
      mismatchCount++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One dot period: drive inputs, queue the expected response, advance the model.
  task automatic step(input bit ce, input bit bg, input bit sp, input bit rst);
    bit ren, en;
    @(negedge clk);
    clkEn = ce;
    backgroundEn = bg;
    spriteEn = sp;
    reset = rst;
    ren = bg | sp;
    en = ce && !rst;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        md[i] = 0;
        ml[i] = 0;
        mo[i] = 1'b0;
      end
      qExp[i].push_back(mk(md[i], ml[i], mo[i], ren, en, visCfg[i], vbCfg[i], preCfg[i]));
      if (en) begin
        if (ml[i] == preCfg[i] && md[i] == 339 && mo[i] && ren) begin
          md[i] = 0;
          ml[i] = 0;
          mo[i] = !mo[i];
        end else begin
          md[i]++;
          if (md[i] == 341) begin
            md[i] = 0;
            ml[i]++;
            if (ml[i] == linesCfg[i]) begin
              ml[i] = 0;
              mo[i] = !mo[i];
            end
          end
        end
      end
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      cycIdx++;
      if (qExp[0].size() > 0) begin
        e = qExp[0].pop_front();
        compareCount++;
        if (bAct !== e) begin
          mismatchCount++;
          if (printed < 20)
            $display("FAIL scoreboard big cycle %0d: got %h, expected %h", cycIdx, bAct, e);
          printed++;
        end
      end
      if (qExp[1].size() > 0) begin
        e = qExp[1].pop_front();
        compareCount++;
        if (sAct !== e) begin
          mismatchCount++;
          if (printed < 20)
            $display("FAIL scoreboard small cycle %0d: got %h, expected %h", cycIdx, sAct, e);
          printed++;
        end
      end
      if (measure && clkEn && !reset) begin
        if (sDot == 9'd0 && sLine == 9'd0) starts.push_back(cycIdx);
        if (sSetVb && vbFirst < 0) vbFirst = cycIdx;
        if (sRstY && sLine == 9'd7) preRstY++;
        if (bLine == 9'd10) begin
          l10IncX += int'(bIncX);
          l10IncY += int'(bIncY);
          l10Both += int'(bIncX && bIncY && bDot == 9'd256);
          l10RstX += int'(bRstX && bDot == 9'd257);
          l10Oam  += int'(bOam);
          l10RstY += int'(bRstY);
        end
      end
      if (reset)
        rstStrobes += int'(bSetVb | bClrVb | bIncX | bIncY | bRstX | bRstY | bOam | bFs |
                           sSetVb | sClrVb | sIncX | sIncY | sRstX | sRstY | sOam | sFs);
    end
  end

  initial begin
    bit bg, sp, found;
    bg = 1'b0;
    sp = 1'b0;
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);

    // Rendering on, continuous enable: frame lengths, skip, per-line strobe counts.
    measure = 1'b1;
    repeat (11200) step(1'b1, 1'b1, 1'b0, 1'b0);
    measure = 1'b0;
    if (starts.size() >= 4) begin
      check("frameLenEven", starts[1] - starts[0], 2728);
      check("frameLenOddSkip", starts[2] - starts[1], 2727);
      check("frameLenEven2", starts[3] - starts[2], 2728);
      check("vblankFirst", vbFirst - starts[0], 5 * 341 + 1);
    end else begin
      check("frameStartsSeen", starts.size(), 4);
    end
    check("line10IncX", l10IncX, 34);
    check("line10IncY", l10IncY, 1);
    check("line10IncXYCoincident", l10Both, 1);
    check("line10ResetX", l10RstX, 1);
    check("line10OamReset", l10Oam, 64);
    check("line10ResetY", l10RstY, 0);
    check("preRenderResetY4Frames", preRstY, 100);

    // Rendering off: no skip on either parity.
    repeat (8200) step(1'b1, 1'b0, 1'b0, 1'b0);

    // Sparse enable with random mid-line mask changes.
    for (int i = 0; i < 20000; i++) begin
      if ($urandom % 64 == 0) begin
        bg = 1'($urandom);
        sp = 1'($urandom);
      end
      step(($urandom % 4) == 0, bg, sp, 1'b0);
    end

    // Run up to line 100 dot 200, then reset with rendering on.
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      if (ml[0] == 100 && md[0] == 200) found = 1'b1;
      else begin
        if ($urandom % 64 == 0) begin
          bg = 1'($urandom);
          sp = 1'($urandom);
        end
        step(($urandom % 4) != 0, bg, sp, 1'b0);
      end
    end
    check("reachedLine100Dot200", int'(found), 1);
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 64 == 0) begin
        bg = 1'($urandom);
        sp = 1'($urandom);
      end
      step(($urandom % 2) == 0, bg, sp, 1'b0);
    end

    @(negedge clk);
    @(negedge clk);
    check("noStrobeDuringReset", rstStrobes, 0);
    check("scoreboardDrainedBig", qExp[0].size(), 0);
    check("scoreboardDrainedSmall", qExp[1].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
